// File: rtl/leaf_tx_packetizer.sv
// Transmit-side BFT leaf endpoint: packs a 32-bit stream into 49-bit BFT packets under credit flow control.
// Optional packet counter output enabled by defining LEAF_TX_PKT_CNT_EN.
module leaf_tx_packetizer #(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int SRC_LEAF      = 1,
    parameter int CREDIT_INIT   = 128
) (
    input  logic                     clk,
    input  logic                     ap_rst_n,
    input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] dest_port,
    input  logic [PAYLOAD_BITS-1:0]  s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
    input  logic                     resend,
    output logic                     credit_err
`ifdef LEAF_TX_PKT_CNT_EN
    ,
    output logic [31:0]              pkt_count
`endif
);

    localparam int VALID_BIT = PACKET_BITS - 1;
    localparam int LEAF_MSB  = PACKET_BITS - 2;
    localparam int PORT_MSB  = LEAF_MSB - NUM_LEAF_BITS;
    localparam int CW        = NUM_ADDR_BITS + 3;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(1) << NUM_ADDR_BITS;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_HOLD
    } state_t;

    state_t                   state;
    logic [NUM_ADDR_BITS:0]   credit;
    logic [NUM_ADDR_BITS-1:0] addr_ptr;
    logic                     handshake;
    logic                     is_credit;
    logic [NUM_ADDR_BITS:0]   credit_n;
    logic [CW-1:0]            credit_sum;
    logic                     credit_clip;
    logic [NUM_ADDR_BITS:0]   credit_next;
    logic [PACKET_BITS-1:0]   data_pkt;
    logic                     unused_din;

    assign s_tready  = (state == S_RUN) && (credit != '0) && !resend;
    assign handshake = s_tvalid && s_tready;
    assign data_pkt  = {1'b1, dest_leaf, dest_port, addr_ptr, s_tdata};

    // Credit returns arrive as port-0 packets addressed to our own leaf.
    assign is_credit = din_leaf_bft2interface[VALID_BIT]
                    && (din_leaf_bft2interface[LEAF_MSB -: NUM_LEAF_BITS] == NUM_LEAF_BITS'(SRC_LEAF))
                    && (din_leaf_bft2interface[PORT_MSB -: NUM_PORT_BITS] == '0);
    assign credit_n   = is_credit ? din_leaf_bft2interface[NUM_ADDR_BITS:0] : '0;
    assign unused_din = ^din_leaf_bft2interface[PAYLOAD_BITS+NUM_ADDR_BITS-1:NUM_ADDR_BITS+1];

    always_comb begin
        credit_sum  = CW'(credit) - CW'(handshake) + CW'(credit_n);
        credit_clip = credit_sum > CREDIT_MAX;
        credit_next = credit_clip ? CREDIT_MAX[NUM_ADDR_BITS:0] : credit_sum[NUM_ADDR_BITS:0];
    end

    // A rejected packet stays on dout until the BFT stops asserting resend; it was already counted.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state                   <= S_INIT;
            dout_leaf_interface2bft <= '0;
            credit                  <= (NUM_ADDR_BITS+1)'(CREDIT_INIT);
            addr_ptr                <= '0;
            credit_err              <= 1'b0;
        end else begin
            credit <= credit_next;
            if (credit_clip) begin
                credit_err <= 1'b1;
            end
            if (handshake) begin
                addr_ptr <= addr_ptr + 1'b1;
            end
            case (state)
                S_INIT: begin
                    state                   <= S_RUN;
                    dout_leaf_interface2bft <= '0;
                end
                S_RUN: begin
                    if (resend && dout_leaf_interface2bft[VALID_BIT]) begin
                        state <= S_HOLD;
                    end else begin
                        dout_leaf_interface2bft <= handshake ? data_pkt : '0;
                    end
                end
                S_HOLD: begin
                    if (!resend) begin
                        state                   <= S_RUN;
                        dout_leaf_interface2bft <= '0;
                    end
                end
                default: begin
                    state                   <= S_INIT;
                    dout_leaf_interface2bft <= '0;
                end
            endcase
        end
    end

`ifdef LEAF_TX_PKT_CNT_EN
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pkt_count <= '0;
        end else if (handshake) begin
            pkt_count <= pkt_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_leaf_tx_packetizer.sv
// Self-checking bench for leaf_tx_packetizer: directed scenarios followed by random traffic
// against a cycle-level transaction model of the packetizer.
module tb_leaf_tx_packetizer;

    logic        clk;
    logic        ap_rst_n;
    logic [4:0]  dest_leaf;
    logic [3:0]  dest_port;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [48:0] din_leaf_bft2interface;
    logic [48:0] dout_leaf_interface2bft;
    logic        resend;
    logic        credit_err;
`ifdef LEAF_TX_PKT_CNT_EN
    logic [31:0] pkt_count;
`endif

    int checks = 0;
    int pass_count = 0;
    int fail_count = 0;

    // Reference model state
    int          m_credit;
    int          m_addr;
    bit          m_running;
    bit          m_holding;
    logic [48:0] m_dout;
    bit          m_err;
    int          m_pkts;

    int          obs_pkts;
    bit          found;
    logic [48:0] held;
    logic [6:0]  next_addr;

    leaf_tx_packetizer dut (
        .clk                     (clk),
        .ap_rst_n                (ap_rst_n),
        .dest_leaf               (dest_leaf),
        .dest_port               (dest_port),
        .s_tdata                 (s_tdata),
        .s_tvalid                (s_tvalid),
        .s_tready                (s_tready),
        .din_leaf_bft2interface  (din_leaf_bft2interface),
        .dout_leaf_interface2bft (dout_leaf_interface2bft),
        .resend                  (resend),
        .credit_err              (credit_err)
`ifdef LEAF_TX_PKT_CNT_EN
        ,
        .pkt_count               (pkt_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [48:0] credit_pkt(input logic [4:0] leaf, input logic [3:0] port,
                                               input logic [31:0] n);
        return {1'b1, leaf, port, 7'd0, n};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_credit  = 128;
        m_addr    = 0;
        m_running = 0;
        m_holding = 0;
        m_dout    = '0;
        m_err     = 0;
        m_pkts    = 0;
    endtask

    // One clock cycle: drive inputs, check ready, advance the model, check registered outputs.
    task automatic applyStimulus(input bit v, input logic [4:0] leaf, input logic [3:0] port,
                                 input logic [31:0] data, input logic [48:0] din, input bit rs);
        bit exp_ready;
        bit hs;
        int n;
        int c;
        s_tvalid               = v;
        dest_leaf              = leaf;
        dest_port              = port;
        s_tdata                = data;
        din_leaf_bft2interface = din;
        resend                 = rs;
        #1;
        exp_ready = m_running && !m_holding && (m_credit != 0) && !rs;
        checkOutput("s_tready", 64'(s_tready), 64'(exp_ready));
        hs = v && exp_ready;
        n = 0;
        if (din[48] && din[47:43] == 5'd1 && din[42:39] == 4'd0) n = int'(din[7:0]);
        c = m_credit - int'(hs) + n;
        if (c > 128) begin
            c     = 128;
            m_err = 1;
        end
        m_credit = c;
        if (!m_running) begin
            m_running = 1;
            m_dout    = '0;
        end else if (m_holding) begin
            if (!rs) begin
                m_holding = 0;
                m_dout    = '0;
            end
        end else if (rs && m_dout[48]) begin
            m_holding = 1;
        end else begin
            m_dout = hs ? {1'b1, leaf, port, 7'(m_addr), data} : 49'd0;
        end
        if (hs) begin
            m_addr = (m_addr + 1) % 128;
            m_pkts++;
        end
        @(posedge clk);
        #1;
        checkOutput("dout", 64'(dout_leaf_interface2bft), 64'(m_dout));
        checkOutput("credit_err", 64'(credit_err), 64'(m_err));
`ifdef LEAF_TX_PKT_CNT_EN
        checkOutput("pkt_count", 64'(pkt_count), 64'(m_pkts));
`endif
    endtask

    // Asynchronous reset taken between clock edges; outputs must clear immediately.
    task automatic doReset();
        ap_rst_n = 1'b0;
        #1;
        checkOutput("rst_dout", 64'(dout_leaf_interface2bft), 64'd0);
        checkOutput("rst_tready", 64'(s_tready), 64'd0);
        checkOutput("rst_credit_err", 64'(credit_err), 64'd0);
`ifdef LEAF_TX_PKT_CNT_EN
        checkOutput("rst_pkt_count", 64'(pkt_count), 64'd0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        ap_rst_n = 1'b1;
    endtask

    initial begin
        ap_rst_n               = 1'b0;
        dest_leaf              = 5'd4;
        dest_port              = 4'd1;
        s_tdata                = 32'hA5A5_0001;
        s_tvalid               = 1'b1;
        din_leaf_bft2interface = '0;
        resend                 = 1'b0;
        model_reset();
        #3;
        checkOutput("init_dout", 64'(dout_leaf_interface2bft), 64'd0);
        checkOutput("init_tready", 64'(s_tready), 64'd0);
        checkOutput("init_credit_err", 64'(credit_err), 64'd0);
        @(posedge clk);
        #1;
        ap_rst_n = 1'b1;

        // First packet after reset: one cycle of S_INIT, then the handshake.
        applyStimulus(1'b1, 5'd4, 4'd1, 32'hA5A5_0001, '0, 1'b0);
        applyStimulus(1'b1, 5'd4, 4'd1, 32'hA5A5_0001, '0, 1'b0);
        checkOutput("first_pkt", 64'(dout_leaf_interface2bft),
                    64'({1'b1, 5'd4, 4'd1, 7'd0, 32'hA5A5_0001}));

        // 130 words with no credit return yield exactly 128 packets.
        obs_pkts = 1;
        for (int i = 0; i < 129; i++) begin
            applyStimulus(1'b1, 5'($urandom), 4'($urandom_range(1, 15)), $urandom, '0, 1'b0);
            if (dout_leaf_interface2bft[48]) obs_pkts++;
        end
        checkOutput("pkts_128", 64'(obs_pkts), 64'd128);
        checkOutput("tready_no_credit", 64'(s_tready), 64'd0);

        // Two credits returned from zero: two packets with wrapped addresses.
        applyStimulus(1'b1, 5'd4, 4'd2, $urandom, credit_pkt(5'd1, 4'd0, 32'd2), 1'b0);
        obs_pkts = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 5'd4, 4'd2, $urandom, '0, 1'b0);
            if (dout_leaf_interface2bft[48]) obs_pkts++;
        end
        checkOutput("pkts_after_2_credits", 64'(obs_pkts), 64'd2);
        checkOutput("tready_drops_again", 64'(s_tready), 64'd0);

        // Resend held for three cycles on the addr-5 packet.
        applyStimulus(1'b1, 5'd7, 4'd3, $urandom, credit_pkt(5'd1, 4'd0, 32'd20), 1'b0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1'b1, 5'd7, 4'd3, $urandom, '0, 1'b0);
            if (dout_leaf_interface2bft[48] && dout_leaf_interface2bft[38:32] == 7'd5) found = 1;
        end
        checkOutput("found_addr5", 64'(found), 64'd1);
        held = dout_leaf_interface2bft;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd7, 4'd3, $urandom, '0, 1'b1);
            checkOutput("hold_dout", 64'(dout_leaf_interface2bft), 64'(held));
        end
        found     = 0;
        next_addr = '0;
        for (int i = 0; i < 4 && !found; i++) begin
            applyStimulus(1'b1, 5'd7, 4'd3, $urandom, '0, 1'b0);
            if (dout_leaf_interface2bft[48]) begin
                found     = 1;
                next_addr = dout_leaf_interface2bft[38:32];
            end
        end
        checkOutput("after_hold_found", 64'(found), 64'd1);
        checkOutput("after_hold_addr", 64'(next_addr), 64'd6);
        obs_pkts = 0;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(1'b1, 5'd7, 4'd3, $urandom, '0, 1'b0);
            if (dout_leaf_interface2bft[48]) obs_pkts++;
        end
        checkOutput("credits_left_after_hold", 64'(obs_pkts), 64'd15);

        // Saturating credit return sets the sticky error; reset mid-stream clears everything.
        doReset();
        applyStimulus(1'b1, 5'd2, 4'd5, $urandom, '0, 1'b0);
        applyStimulus(1'b1, 5'd2, 4'd5, $urandom, '0, 1'b0);
        applyStimulus(1'b1, 5'd2, 4'd5, $urandom, credit_pkt(5'd1, 4'd0, 32'd3), 1'b0);
        checkOutput("credit_err_set", 64'(credit_err), 64'd1);
        applyStimulus(1'b1, 5'd2, 4'd5, $urandom, '0, 1'b0);
        checkOutput("mid_stream_valid", 64'(dout_leaf_interface2bft[48]), 64'd1);
        #2;
        doReset();
        obs_pkts = 0;
        for (int i = 0; i < 131; i++) begin
            applyStimulus(1'b1, 5'($urandom), 4'($urandom_range(1, 15)), $urandom, '0, 1'b0);
            if (dout_leaf_interface2bft[48]) obs_pkts++;
        end
        checkOutput("credit_reinit_128", 64'(obs_pkts), 64'd128);

        // Random traffic: credit returns (some foreign or invalid), resends, gaps.
        for (int i = 0; i < 400; i++) begin
            logic [48:0] din;
            int          r;
            r   = $urandom_range(0, 15);
            din = '0;
            case (r)
                0: din = credit_pkt(5'd1, 4'd0, {$urandom_range(0, 255), 8'($urandom_range(0, 12))} & 32'h00FF_FFFF);
                1: din = credit_pkt(5'd9, 4'd0, 32'd5);
                2: din = credit_pkt(5'd1, 4'd3, 32'd5);
                3: din = {1'b0, 5'd1, 4'd0, 7'd0, 32'd5};
                default: din = '0;
            endcase
            applyStimulus($urandom_range(0, 3) != 0, 5'($urandom), 4'($urandom_range(1, 15)),
                          $urandom, din, $urandom_range(0, 5) == 0);
        end

`ifdef LEAF_TX_PKT_CNT_EN
        // Ten handshakes with a four-cycle resend in the middle count as ten.
        resend = 1'b0;
        doReset();
        applyStimulus(1'b0, 5'd3, 4'd1, 32'd0, '0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 5'd3, 4'd1, $urandom, '0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'd3, 4'd1, 32'd0, '0, 1'b1);
        applyStimulus(1'b0, 5'd3, 4'd1, 32'd0, '0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 5'd3, 4'd1, $urandom, '0, 1'b0);
        applyStimulus(1'b0, 5'd3, 4'd1, 32'd0, '0, 1'b0);
        checkOutput("pkt_count_10", 64'(pkt_count), 64'd10);
`endif

        $display("%0d/%0d checks passed", pass_count, checks);
        $finish;
    end

endmodule
